// File: rtl/enc8to3_pending_pkg.sv
// Shared definitions for the pending-request 8-to-3 priority encoder.
package enc8to3_pending_pkg;

  localparam int DEF_W  = 8;
  localparam int DEF_CW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [DEF_CW-1:0] lsb_index(input logic [DEF_W-1:0] vec);
    logic [DEF_CW-1:0] idx;
    idx = {DEF_CW{1'b0}};
    for (int i = DEF_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = DEF_CW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/enc8to3_pending_prio.sv
// Combinational lowest-set-bit encoder with an any-set flag.
module prio_enc8to3
  import enc8to3_pending_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) (
  input  logic [W-1:0]  req,
  output logic [CW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = {CW{1'b0}};
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = CW'(i);
      end else begin
        idx = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/enc8to3_pending.sv
// Registered priority encoder: captures request pulses into a pending
// register and serves the lowest pending index under a valid/ack handshake.
module enc8to3_pending
  import enc8to3_pending_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in,
  input  logic          en,
  input  logic          ack,
  output logic [CW-1:0] out,
  output logic          valid,
  output logic [W-1:0]  pend,
  output logic          ovf
);

  state_t        state_r, state_s;
  logic [CW-1:0] out_r, out_s;
  logic          valid_r, valid_s;
  logic [W-1:0]  pend_r, pend_s;
  logic          ovf_r, ovf_s;
  logic [W-1:0]  clr_mask_s;
  logic [CW-1:0] idx_s;
  logic          any_s;

  prio_enc8to3 #(
    .W  (W),
    .CW (CW)
  ) u_prio (
    .req (pend_r),
    .idx (idx_s),
    .any (any_s)
  );

  // Grant/handshake next-state, served-bit clear mask and pending/overflow update.
  always_comb begin
    state_s    = state_r;
    out_s      = out_r;
    valid_s    = valid_r;
    clr_mask_s = {W{1'b0}};
    case (state_r)
      IDLE: begin
        if (en && any_s) begin
          out_s   = idx_s;
          valid_s = 1'b1;
          state_s = HOLD;
        end else begin
          valid_s = 1'b0;
          state_s = IDLE;
        end
      end
      HOLD: begin
        // en is deliberately ignored here: a grant is never withdrawn.
        if (ack) begin
          valid_s    = 1'b0;
          clr_mask_s = {{(W-1){1'b0}}, 1'b1} << out_r;
          state_s    = IDLE;
        end else begin
          valid_s = 1'b1;
          state_s = HOLD;
        end
      end
      default: begin
        valid_s = 1'b0;
        state_s = IDLE;
      end
    endcase
    // Set after clear so a same-cycle re-request on the served bit stays pending.
    pend_s = (pend_r & ~clr_mask_s) | in;
    ovf_s  = ovf_r | (|(in & pend_r & ~clr_mask_s));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      out_r   <= {CW{1'b0}};
      valid_r <= 1'b0;
      pend_r  <= {W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      out_r   <= out_s;
      valid_r <= valid_s;
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
    end
  end

  assign out   = out_r;
  assign valid = valid_r;
  assign pend  = pend_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_enc8to3_pending.sv
// Directed and random stimulus for enc8to3_pending against a behavioural model.
module tb_enc8to3_pending;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in  = 8'h00;
  logic       en  = 1'b0;
  logic       ack = 1'b0;
  logic [2:0] out;
  logic       valid;
  logic [7:0] pend;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_pend  = 8'h00;
  int         m_out   = 0;
  bit         m_serve = 1'b0;
  bit         m_ovf   = 1'b0;

  enc8to3_pending dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .en    (en),
    .ack   (ack),
    .out   (out),
    .valid (valid),
    .pend  (pend),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int k = 0; k < 8; k++)
      if (v[k]) return k;
    return 0;
  endfunction

  task automatic model(input logic [7:0] i, input bit e, input bit a, input bit r);
    logic [7:0] served;
    if (r) begin
      m_pend = 8'h00; m_out = 0; m_serve = 1'b0; m_ovf = 1'b0;
      return;
    end
    served = 8'h00;
    if (m_serve && a) served[m_out] = 1'b1;
    if ((i & m_pend & ~served) != 8'h00) m_ovf = 1'b1;
    if (m_serve) begin
      if (a) m_serve = 1'b0;
    end else if (e && m_pend != 8'h00) begin
      m_out   = lowest(m_pend);
      m_serve = 1'b1;
    end
    m_pend = (m_pend & ~served) | i;
  endtask

  task automatic step(input logic [7:0] i, input bit e, input bit a, input bit r);
    @(negedge clk);
    in = i; en = e; ack = a; rst = r;
    @(posedge clk);
    model(i, e, a, r);
    #1;
    chk("valid", {31'd0, valid}, {31'd0, m_serve});
    chk("pend", {24'd0, pend}, {24'd0, m_pend});
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    chk("out", {29'd0, out}, m_out);
  endtask

  initial begin
    int seq[3];
    seq = '{1, 3, 7};

    // Reset holds everything clear even with all requests high
    step(8'hFF, 1'b0, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b0, 1'b1);
    chk("rst_pend", {24'd0, pend}, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'h0);
    chk("rst_out", {29'd0, out}, 32'h0);
    chk("rst_ovf", {31'd0, ovf}, 32'h0);
    step(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("rst_release_pend", {24'd0, pend}, 32'hFF);
    step(8'h00, 1'b0, 1'b0, 1'b1);

    // Single request
    step(8'h20, 1'b1, 1'b0, 1'b0);
    chk("single_wait", {31'd0, valid}, 32'h0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    chk("single_valid", {31'd0, valid}, 32'h1);
    chk("single_out", {29'd0, out}, 32'd5);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("single_ack_valid", {31'd0, valid}, 32'h0);
    chk("single_ack_pend", {24'd0, pend}, 32'h0);

    // Priority drain 1,3,7 with an idle bubble between grants
    step(8'h8A, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain_out", {29'd0, out}, seq[g]);
      chk("drain_valid", {31'd0, valid}, 32'h1);
      step(8'h00, 1'b1, 1'b1, 1'b0);
      chk("drain_bubble", {31'd0, valid}, 32'h0);
    end
    chk("drain_pend", {24'd0, pend}, 32'h0);

    // Grant held while en drops and a higher-priority request arrives
    step(8'h08, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    chk("hold_out", {29'd0, out}, 32'd3);
    step(8'h01, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    chk("hold_keep", {29'd0, out}, 32'd3);
    chk("hold_valid", {31'd0, valid}, 32'h1);
    step(8'h00, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    chk("hold_en_off", {31'd0, valid}, 32'h0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    chk("hold_next", {29'd0, out}, 32'd0);
    step(8'h00, 1'b1, 1'b1, 1'b0);

    // Re-request on the bit being cleared survives without overflow
    step(8'h10, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    chk("coll_out", {29'd0, out}, 32'd4);
    step(8'h10, 1'b1, 1'b1, 1'b0);
    chk("coll_pend", {24'd0, pend}, 32'h10);
    chk("coll_ovf", {31'd0, ovf}, 32'h0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    chk("coll_regrant", {29'd0, out}, 32'd4);
    step(8'h00, 1'b1, 1'b1, 1'b0);

    // Overflow is sticky until reset
    step(8'h04, 1'b0, 1'b0, 1'b0);
    step(8'h04, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, ovf}, 32'h1);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    chk("ovf_sticky", {31'd0, ovf}, 32'h1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clear", {31'd0, ovf}, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r_in;
      r_in = 8'($urandom) & 8'($urandom) & 8'($urandom);
      step(r_in, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
